lsu_unit: RTL and testbench

Load/store unit directly downstream of the ALU in the RV32I datapath. It consumes the ALU's effective address (rs1 + imm) plus store data and funct3. It runs a single outstanding data-memory transaction over a valid/ready request and rvalid response handshake, then returns an aligned, extended load result to writeback. Misaligned and illegal accesses are flagged without touching memory.

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/lsu_unit_if.sv | 25 ++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu_unit.sv | 134 +++++++++++++
 tb/tb_lsu_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: data width, funct3 width/sign codes
// and the LSU sequencing state encodings.
package rv32i_pkg;

    localparam int XLEN = 32;

    // funct3 encodings for loads and stores. Stores only use B/H/W.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // LSU sequencing states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/lsu_unit_if.sv
// Data-memory bus between the LSU (master) and the memory (slave):
// valid/ready request channel plus an rvalid read response.
interface lsu_unit_if;
    import rv32i_pkg::*;

    logic            mem_valid;
    logic            mem_ready;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store byte enables and replicated write
// data, and extraction plus sign/zero extension of the loaded value.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);

    logic [XLEN-1:0] shifted;

    // Lane enables and replicated store data; funct3[1:0] carries the width.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << offset;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Move the addressed byte/half down to bit 0, then extend per funct3.
    always_comb begin
        shifted   = rdata >> {offset, 3'b000};
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'd0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// RV32I load/store unit: accepts one memory op from execute, checks
// alignment/encoding, runs a single data-memory transaction and returns
// the extended load result to writeback.
//
// state | meaning
// IDLE  | ready for a new op (req_ready=1)
// REQ   | mem_valid held with stable address/data until mem_ready
// WAIT  | load issued, waiting for mem_rvalid
// DONE  | one-cycle completion pulse (done, err, writeback)
module lsu_unit
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  addr,
    input  logic [XLEN-1:0]  store_data,
    input  logic [REG_W-1:0] rd,
    lsu_unit_if.master       mem,
    output logic             done,
    output logic             wb_we,
    output logic [REG_W-1:0] wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic             err
);

    logic [1:0]       state;
    logic             is_store_q;
    logic [2:0]       f3_q;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  sd_q;
    logic [REG_W-1:0] rd_q;
    logic [XLEN-1:0]  rdata_q;
    logic             err_q;
    logic             legal;
    logic             in_req;
    logic             in_done;
    logic [3:0]       be;
    logic [XLEN-1:0]  wdata;
    logic [XLEN-1:0]  load_data;

    lsu_align u_align (
        .funct3     (f3_q),
        .offset     (addr_q[1:0]),
        .store_data (sd_q),
        .rdata      (rdata_q),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data)
    );

    // Alignment and encoding check on the incoming request.
    always_comb begin
        legal = 1'b0;
        case (funct3)
            F3_B:    legal = 1'b1;
            F3_H:    legal = ~addr[0];
            F3_W:    legal = (addr[1:0] == 2'b00);
            F3_BU:   legal = ~is_store;
            F3_HU:   legal = ~is_store & ~addr[0];
            default: legal = 1'b0;
        endcase
    end

    // Sequencer and request/response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            is_store_q <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= '0;
            sd_q       <= '0;
            rd_q       <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        is_store_q <= is_store;
                        f3_q       <= funct3;
                        addr_q     <= addr;
                        sd_q       <= store_data;
                        rd_q       <= rd;
                        rdata_q    <= '0;
                        err_q      <= ~legal;
                        state      <= legal ? ST_REQ : ST_DONE;
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ready) begin
                        state <= is_store_q ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem.mem_rvalid) begin
                        rdata_q <= mem.mem_rdata;
                        state   <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_req  = (state == ST_REQ);
    assign in_done = (state == ST_DONE);

    // Bus outputs are forced to zero outside REQ so idle cycles are clean.
    always_comb begin
        mem.mem_valid = in_req;
        mem.mem_we    = in_req & is_store_q;
        mem.mem_addr  = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
        mem.mem_be    = in_req ? be : 4'b0000;
        mem.mem_wdata = (in_req & is_store_q) ? wdata : '0;
    end

    // Completion and writeback; data only escapes for a legal load.
    always_comb begin
        req_ready = (state == ST_IDLE);
        done      = in_done;
        err       = in_done & err_q;
        wb_we     = in_done & ~is_store_q & ~err_q;
        wb_rd     = wb_we ? rd_q : '0;
        wb_data   = wb_we ? load_data : '0;
    end

endmodule

// File: tb/tb_lsu_unit.sv
module tb_lsu_unit;

    typedef struct {
        logic        err;
        logic        wb_we;
        logic [4:0]  rd;
        logic [31:0] data;
    } done_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd = '0;
    logic        done;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

    int errors = 0;
    int checks = 0;

    done_exp_t done_q[$];
    mem_exp_t  mem_q[$];
    mem_exp_t  mem_hold;
    logic      prev_mv = 1'b0;

    lsu_unit_if mem_bus ();

    lsu_unit #(.XLEN(32), .REG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .rd         (rd),
        .mem        (mem_bus),
        .done       (done),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: memory requests and completions checked against the queues.
    always @(negedge clk) begin
        if (rst_n && mem_bus.mem_valid) begin
            if (!prev_mv) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem_valid", 32'd1, 32'd0);
                end else begin
                    mem_exp_t e;
                    e = mem_q.pop_front();
                    chk("mem_we", {31'd0, mem_bus.mem_we}, {31'd0, e.we});
                    chk("mem_addr", mem_bus.mem_addr, e.addr);
                    chk("mem_be", {28'd0, mem_bus.mem_be}, {28'd0, e.be});
                    if (e.we) chk("mem_wdata", mem_bus.mem_wdata, e.wdata);
                end
                mem_hold.we    = mem_bus.mem_we;
                mem_hold.addr  = mem_bus.mem_addr;
                mem_hold.be    = mem_bus.mem_be;
                mem_hold.wdata = mem_bus.mem_wdata;
            end else begin
                chk("mem_stable",
                    {mem_bus.mem_addr[31:2], mem_bus.mem_we, 1'b0} ^ {28'd0, mem_bus.mem_be} ^ mem_bus.mem_wdata,
                    {mem_hold.addr[31:2], mem_hold.we, 1'b0} ^ {28'd0, mem_hold.be} ^ mem_hold.wdata);
            end
        end
        if (rst_n && done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                done_exp_t d;
                d = done_q.pop_front();
                chk("err", {31'd0, err}, {31'd0, d.err});
                chk("wb_we", {31'd0, wb_we}, {31'd0, d.wb_we});
                chk("wb_data", wb_data, d.data);
                if (d.wb_we) chk("wb_rd", {27'd0, wb_rd}, {27'd0, d.rd});
            end
        end
        prev_mv <= mem_bus.mem_valid;
    end

    // One op: push expectations, issue, act as memory, measure latency.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [4:0] r, input logic [31:0] rdv,
                          input int rw, input bit legal, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] ewb, input int elat);
        int lat;
        int mv;
        int waits;
        bit rvn;
        done_exp_t d;
        mem_exp_t m;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        if (legal) begin
            m.we = st; m.addr = {a[31:2], 2'b00}; m.be = ebe; m.wdata = ewd;
            mem_q.push_back(m);
        end
        d.err = ~legal; d.wb_we = legal & ~st; d.rd = r; d.data = ewb;
        done_q.push_back(d);
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; rd = r;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; mv = 0; waits = 0; rvn = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            mem_bus.mem_ready  = 1'b0;
            mem_bus.mem_rvalid = 1'b0;
            mem_bus.mem_rdata  = 32'h1234_5678;
            if (done) begin
                lat = c;
                chk("req_ready_in_done", {31'd0, req_ready}, 32'd0);
                break;
            end
            if (mem_bus.mem_valid) begin
                mv++;
                if (waits < rw) waits++;
                else begin
                    mem_bus.mem_ready = 1'b1;
                    rvn = ~st;
                end
            end else if (rvn) begin
                mem_bus.mem_rvalid = 1'b1;
                mem_bus.mem_rdata  = rdv;
                rvn = 1'b0;
            end
        end
        chk("latency", lat, elat);
        chk("mem_valid_cycles", mv, legal ? rw + 1 : 0);
    endtask

    initial begin
        mem_bus.mem_ready  = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = '0;
        #2;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_valid", {31'd0, mem_bus.mem_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // st f3 addr store_data rd rdata wait legal be wdata wb_data latency
        run_op(0, 3'b010, 32'h1000, 32'h0, 5'd5, 32'hDEAD_BEEF, 0, 1, 4'b1111, 32'h0, 32'hDEAD_BEEF, 3);
        run_op(0, 3'b000, 32'h1003, 32'h0, 5'd6, 32'h80FF_0000, 0, 1, 4'b1000, 32'h0, 32'hFFFF_FF80, 3);
        run_op(0, 3'b100, 32'h1003, 32'h0, 5'd7, 32'h80FF_0000, 0, 1, 4'b1000, 32'h0, 32'h0000_0080, 3);
        run_op(0, 3'b001, 32'h1002, 32'h0, 5'd8, 32'h8001_1234, 2, 1, 4'b1100, 32'h0, 32'hFFFF_8001, 5);
        run_op(1, 3'b001, 32'h2002, 32'h0000_ABCD, 5'd9, 32'h0, 3, 1, 4'b1100, 32'hABCD_ABCD, 32'h0, 5);
        run_op(1, 3'b010, 32'h2004, 32'h1234_5678, 5'd1, 32'h0, 0, 1, 4'b1111, 32'h1234_5678, 32'h0, 2);
        run_op(0, 3'b010, 32'h1001, 32'h0, 5'd2, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1);
        run_op(1, 3'b001, 32'h1001, 32'h0, 5'd3, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1);
        run_op(1, 3'b100, 32'h2000, 32'hFF, 5'd4, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1);
        run_op(0, 3'b011, 32'h2000, 32'h0, 5'd4, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0, 1);
        run_op(1, 3'b000, 32'h3001, 32'h55, 5'd10, 32'h0, 0, 1, 4'b0010, 32'h5555_5555, 32'h0, 2);
        run_op(0, 3'b101, 32'h3002, 32'h0, 5'd11, 32'hBEEF_1234, 0, 1, 4'b1100, 32'h0, 32'h0000_BEEF, 3);

        // Reset while a load waits for its response; the late response must be dropped.
        begin
            mem_exp_t m;
            @(negedge clk);
            m.we = 1'b0; m.addr = 32'h4000; m.be = 4'b1111; m.wdata = '0;
            mem_q.push_back(m);
            req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h4000; rd = 5'd7;
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            chk("rst_case_req", {31'd0, mem_bus.mem_valid}, 32'd1);
            mem_bus.mem_ready = 1'b1;
            @(negedge clk);
            mem_bus.mem_ready = 1'b0;
            rst_n = 1'b0;
            #1;
            chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
            chk("midrst_mem_valid", {31'd0, mem_bus.mem_valid}, 32'd0);
            chk("midrst_done", {31'd0, done}, 32'd0);
            chk("midrst_wb_we", {31'd0, wb_we}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            mem_bus.mem_rvalid = 1'b1;
            mem_bus.mem_rdata  = 32'hCAFE_F00D;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                mem_bus.mem_rvalid = 1'b0;
                chk("stray_rvalid_done", {31'd0, done | wb_we}, 32'd0);
                chk("stray_rvalid_ready", {31'd0, req_ready}, 32'd1);
            end
        end

        repeat (3) @(negedge clk);
        chk("done_queue_empty", done_q.size(), 32'd0);
        chk("mem_queue_empty", mem_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
